input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//  Parametrised successor to the two-flop input synchroniser on the TT top level.
//  Per channel: optional inversion, an N-stage synchroniser, a tick-gated debouncer,
//  and registered one-cycle rise/fall pulses.
//  Sits between ui_in pins and game/control logic. Feeds clean level and edge
//  strobes to pause, new-game and up/down key consumers.
// PARAMETERS
//  CHANNELS         4        number of independent input channels (>=1)
//  SYNC_STAGES      2        synchroniser flops per channel (>=2)
//  DEBOUNCE_CYCLES  4        consecutive qualifying ticks before level changes (>=1)
//  INVERT_MASK      {CH{1}}  bit i=1: channel i inverted before sync (pins idle low)
// PORTS
//  clk          in   1         system clock (25.175 MHz nominal)
//  reset        in   1         synchronous, active-high reset
//  debounce_en  in   1         1: debounce active; 0: bypass, level follows synced input
//  tick         in   1         debounce sample strobe (tie 1 for per-clock counting)
//  raw_in       in   CHANNELS  asynchronous pin inputs
//  level_out    out  CHANNELS  debounced, conditioned level
//  rise_out     out  CHANNELS  1-cycle pulse, first cycle level_out[i] is 1
//  fall_out     out  CHANNELS  1-cycle pulse, first cycle level_out[i] is 0
// BEHAVIOUR
//  - Reset: every sync flop and level_out[i] load INVERT_MASK[i], i.e. the value
//    for raw_in=0. Counters = 0; rise_out = fall_out = 0.
//  - Idle-low pins produce no spurious edge after reset release.
//  - Reset mid-count: counter cleared, level_out held at reset value, no pulse.
//  - Conditioning: c[i] = raw_in[i] ^ INVERT_MASK[i], then SYNC_STAGES-deep shift chain.
//    Last stage is synced[i]. Latency from raw_in to synced is SYNC_STAGES clocks.
//  - Debounce (debounce_en=1), per channel:
//      - synced == level: counter <= 0.
//      - synced != level and tick=0: counter holds.
//      - synced != level, tick=1, counter < DEBOUNCE_CYCLES-1: counter++.
//      - synced != level, tick=1, counter == DEBOUNCE_CYCLES-1:
//        level <= synced, counter <= 0.
//      - Any return of synced to level before commit restarts the count.
//  - Counter width: $clog2(DEBOUNCE_CYCLES+1). The counter never exceeds
//    DEBOUNCE_CYCLES-1 and does not wrap.
//  - Bypass (debounce_en=0): level <= synced every clock; counter forced 0.
//    Switching debounce_en mid-count clears the counter.
//  - Edges: rise_out[i] <= (level 0->1 this clock); fall_out[i] <= (level 1->0).
//    Pulses are registered alongside level, so each pulse coincides with the
//    first cycle of the new level_out value. Never 2 cycles wide.
//  - Channels are fully independent. Simultaneous changes give same-cycle pulses
//    on each channel.
//  - tick is sampled only on the commit/count decision. tick has no effect in bypass.
// STRUCTURE
//  - Shared package io_cond_pkg holds the default DEBOUNCE_CYCLES for
//    25 MHz / 60 Hz tick use and the counter-width helper function.
//  - One sub-module: input_conditioner_ch. It contains the single-channel
//    sync chain, counter, level and edge registers.
//  - The top generates CHANNELS instances. It passes INVERT_MASK[i] as a
//    1-bit parameter to each instance.
// TESTING  (CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, INVERT_MASK=4'b1111, tick=1)
//  1. reset=1 for 3 clk, raw_in=0, then release and run 20 clk
//     -> level_out=4'b1111 throughout, rise_out=fall_out=0 throughout.
//  2. raw_in[0] 0->1 and held
//     -> synced differs after 2 clk. level_out[0]=0 from the 6th clk edge after
//        the change. fall_out[0]=1 for exactly that one cycle; rise_out=0.
//  3. raw_in[1] toggled every 2 clk for 20 clk, then settled 0
//     -> level_out[1] stays 1, no pulses on any channel.
//  4. tick high 1 clk in 10; raw_in[2]=1 held for 30 clk then released
//     -> no change. Then held 60 clk -> level_out[2]=0 on the 4th qualifying tick
//        after sync, with a single fall_out[2].
//  5. debounce_en=0; raw_in[3] 0->1 -> level_out[3]=0 after 3 clk with fall_out[3]
//     pulse. raw_in[3] 1->0 -> level_out[3]=1 after 3 clk with rise_out[3] pulse.
//  6. raw_in[2], raw_in[3] rise in the same clk -> both fall pulses in the same cycle.
//     Repeat with reset asserted when counter=3 -> no pulse, level_out stays 4'b1111.

Source files
------------

// File: rtl/io_cond_pkg.sv
// Shared constants and helpers for the input conditioner.
// Defaults are sized for a 25.175 MHz clock with a 60 Hz debounce tick.
package io_cond_pkg;

   // Four 60 Hz ticks is roughly 67 ms, enough to cover typical key bounce.
   localparam int unsigned IO_COND_DEBOUNCE_CYCLES = 4;

   function automatic int unsigned io_cond_cnt_width(input int unsigned debounce_cycles);
      return $clog2(debounce_cycles + 1);
   endfunction

endpackage

// File: rtl/input_conditioner_ch.sv
// Single input channel: inversion, N-stage synchroniser, tick-gated debouncer
// and registered one-cycle rise/fall strobes aligned with the new level.
module input_conditioner_ch
   import io_cond_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = IO_COND_DEBOUNCE_CYCLES,
   parameter logic        INVERT          = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic debounce_en,
   input  logic tick,
   input  logic raw_in,
   output logic level_out,
   output logic rise_out,
   output logic fall_out
);

   localparam int unsigned         CW       = io_cond_cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]       CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic [CW-1:0]          cnt_q;
   logic [CW-1:0]          cnt_d;
   logic                   level_q;
   logic                   level_d;

   assign synced = sync_q[SYNC_STAGES-1];

   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      if (!debounce_en) begin
         level_d = synced;
         cnt_d   = '0;
      end else if (synced == level_q) begin
         cnt_d = '0;
      end else if (tick) begin
         if (cnt_q == CNT_LAST) begin
            level_d = synced;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Reset loads the conditioned value of an idle pin so release causes no edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q   <= {SYNC_STAGES{INVERT}};
         cnt_q    <= '0;
         level_q  <= INVERT;
         rise_out <= 1'b0;
         fall_out <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_in ^ INVERT};
         cnt_q    <= cnt_d;
         level_q  <= level_d;
         rise_out <= ~level_q & level_d;
         fall_out <= level_q & ~level_d;
      end
   end

   assign level_out = level_q;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: one independent conditioning channel per pin,
// each with its own inversion setting taken from INVERT_MASK.
module input_conditioner
   import io_cond_pkg::*;
#(
   parameter int unsigned           CHANNELS        = 4,
   parameter int unsigned           SYNC_STAGES     = 2,
   parameter int unsigned           DEBOUNCE_CYCLES = IO_COND_DEBOUNCE_CYCLES,
   parameter logic [CHANNELS-1:0]   INVERT_MASK     = '1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                debounce_en,
   input  logic                tick,
   input  logic [CHANNELS-1:0] raw_in,
   output logic [CHANNELS-1:0] level_out,
   output logic [CHANNELS-1:0] rise_out,
   output logic [CHANNELS-1:0] fall_out
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      input_conditioner_ch #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .INVERT         (INVERT_MASK[i])
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .debounce_en(debounce_en),
         .tick       (tick),
         .raw_in     (raw_in[i]),
         .level_out  (level_out[i]),
         .rise_out   (rise_out[i]),
         .fall_out   (fall_out[i])
      );
   end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a per-cycle behavioural reference
// model plus hand-computed checkpoints.
module tb_input_conditioner;

   localparam int       CH   = 4;
   localparam int       SYNC = 2;
   localparam int       DEB  = 4;
   localparam logic [3:0] INV = 4'b1111;

   logic          clk = 1'b0;
   logic          reset;
   logic          debounce_en;
   logic          tick;
   logic [CH-1:0] raw_in;
   logic [CH-1:0] level_out;
   logic [CH-1:0] rise_out;
   logic [CH-1:0] fall_out;

   int n_checks = 0;
   int n_fail   = 0;

   input_conditioner #(
      .CHANNELS       (CH),
      .SYNC_STAGES    (SYNC),
      .DEBOUNCE_CYCLES(DEB),
      .INVERT_MASK    (INV)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .debounce_en(debounce_en),
      .tick       (tick),
      .raw_in     (raw_in),
      .level_out  (level_out),
      .rise_out   (rise_out),
      .fall_out   (fall_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: synced is the conditioned input seen SYNC clocks earlier;
   // a level changes once the mismatch has persisted for DEB ticks.
   logic [CH-1:0] hist[$];
   logic [CH-1:0] m_level, m_rise, m_fall, m_prev, s;
   int            run_ticks[CH];
   bit            model_valid = 0;

   always @(posedge clk) begin
      if (reset) begin
         hist.delete();
         for (int i = 0; i < SYNC; i++) hist.push_back(INV);
         m_level = INV;
         m_rise  = '0;
         m_fall  = '0;
         for (int c = 0; c < CH; c++) run_ticks[c] = 0;
         model_valid = 1;
      end else if (model_valid) begin
         s      = hist[0];
         m_prev = m_level;
         for (int c = 0; c < CH; c++) begin
            if (!debounce_en) begin
               m_level[c]   = s[c];
               run_ticks[c] = 0;
            end else if (s[c] == m_level[c]) begin
               run_ticks[c] = 0;
            end else if (tick) begin
               run_ticks[c] = run_ticks[c] + 1;
               if (run_ticks[c] >= DEB) begin
                  m_level[c]   = s[c];
                  run_ticks[c] = 0;
               end
            end
         end
         m_rise = ~m_prev & m_level;
         m_fall = m_prev & ~m_level;
         hist.push_back(raw_in ^ INV);
         void'(hist.pop_front());
      end
      #1;
      if (model_valid) begin
         chk("model_level", 32'(level_out), 32'(m_level));
         chk("model_rise",  32'(rise_out),  32'(m_rise));
         chk("model_fall",  32'(fall_out),  32'(m_fall));
      end
   end

   // Stimulus helpers: inputs change on negedge; tick can run sparse (1 in 10).
   bit            tick_sparse = 0;
   int            tick_phase  = 0;
   logic [CH-1:0] pulse_acc;
   int            fall2_cnt;

   task automatic clocks(input int n);
      repeat (n) begin
         @(negedge clk);
         pulse_acc = pulse_acc | rise_out | fall_out;
         if (fall_out[2]) fall2_cnt++;
         tick_phase = (tick_phase + 1) % 10;
         tick = tick_sparse ? (tick_phase == 0) : 1'b1;
      end
   endtask

   initial begin
      reset       = 1'b1;
      debounce_en = 1'b1;
      tick        = 1'b1;
      raw_in      = '0;
      pulse_acc   = '0;
      fall2_cnt   = 0;

      // 1: reset and idle
      clocks(3);
      reset = 1'b0;
      chk("reset_level", 32'(level_out), 32'h0000000f);
      chk("reset_rise",  32'(rise_out),  32'h0);
      chk("reset_fall",  32'(fall_out),  32'h0);
      pulse_acc = '0;
      clocks(20);
      chk("idle_level", 32'(level_out), 32'h0000000f);
      chk("idle_pulses", 32'(pulse_acc), 32'h0);

      // 2: channel 0 press, commits on the 6th edge
      raw_in[0] = 1'b1;
      clocks(5);
      chk("ch0_edge5_level", 32'(level_out[0]), 32'h1);
      clocks(1);
      chk("ch0_edge6_level", 32'(level_out[0]), 32'h0);
      chk("ch0_edge6_fall",  32'(fall_out[0]),  32'h1);
      chk("ch0_edge6_rise",  32'(rise_out),     32'h0);
      clocks(1);
      chk("ch0_edge7_fall",  32'(fall_out[0]),  32'h0);

      // 3: bouncing channel 1 never commits
      pulse_acc = '0;
      for (int k = 0; k < 10; k++) begin
         raw_in[1] = ~raw_in[1];
         clocks(2);
      end
      raw_in[1] = 1'b0;
      clocks(10);
      chk("bounce_level",  32'(level_out), 32'h0000000e);
      chk("bounce_pulses", 32'(pulse_acc), 32'h0);

      // 4: sparse ticks; 30 clk of mismatch spans only 3 ticks
      tick_sparse = 1;
      raw_in[2]   = 1'b1;
      clocks(30);
      raw_in[2]   = 1'b0;
      clocks(10);
      chk("sparse_short_level", 32'(level_out[2]), 32'h1);
      fall2_cnt = 0;
      raw_in[2] = 1'b1;
      clocks(60);
      chk("sparse_long_level", 32'(level_out[2]), 32'h0);
      chk("sparse_fall_count", 32'(fall2_cnt),    32'h1);
      tick_sparse = 0;
      tick        = 1'b1;

      // 5: bypass on channel 3
      debounce_en = 1'b0;
      raw_in[3]   = 1'b1;
      clocks(2);
      chk("bypass_edge2_level", 32'(level_out[3]), 32'h1);
      clocks(1);
      chk("bypass_press_level", 32'(level_out[3]), 32'h0);
      chk("bypass_press_fall",  32'(fall_out[3]),  32'h1);
      raw_in[3] = 1'b0;
      clocks(3);
      chk("bypass_release_level", 32'(level_out[3]), 32'h1);
      chk("bypass_release_rise",  32'(rise_out[3]),  32'h1);
      debounce_en = 1'b1;

      // 6: simultaneous presses, then reset while counters sit at 3
      raw_in = '0;
      clocks(10);
      chk("settle_level", 32'(level_out), 32'h0000000f);
      raw_in[3:2] = 2'b11;
      clocks(6);
      chk("simul_fall",  32'(fall_out),  32'h0000000c);
      chk("simul_level", 32'(level_out), 32'h00000003);
      raw_in = '0;
      clocks(10);
      pulse_acc   = '0;
      raw_in[3:2] = 2'b11;
      clocks(5);
      reset  = 1'b1;
      raw_in = '0;
      clocks(1);
      chk("midreset_level", 32'(level_out), 32'h0000000f);
      chk("midreset_fall",  32'(fall_out),  32'h0);
      reset = 1'b0;
      clocks(10);
      chk("midreset_after_level",  32'(level_out), 32'h0000000f);
      chk("midreset_after_pulses", 32'(pulse_acc), 32'h0);

      clocks(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
